// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector with overlap control and saturating match counter
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   x, x_valid   serial data bit and its qualifier
//   overlap      1 = matches may share bits, 0 = each match needs len fresh bits
//   load         capture pat_in/len_in and restart the search
//   pat_in       new pattern, bit len-1 received first, bit 0 last
//   len_in       new pattern length (clamped to MAX_LEN, 0 disables detection)
//   clr_cnt      synchronous clear of match_count
//   y            registered one-cycle match pulse
//   match_count  saturating count of matches
//   cnt_sat      match_count is all-ones
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LW = 4,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0001_0110,
  parameter logic [LW-1:0] DEF_LEN = 4'd5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);
  logic [MAX_LEN-1:0] pat, hist, hist_nxt, mask;
  logic [LW-1:0] len, fill, fill_nxt, len_clamp;
  logic match;
  assign len_clamp = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;
  assign hist_nxt = {hist[MAX_LEN-2:0], x};
  // fill never exceeds len, so fill+1 always fits in LW bits
  assign fill_nxt = (fill == len) ? len : fill + LW'(1);
  assign mask = ~({MAX_LEN{1'b1}} << len);
  // len==0 would trivially compare equal under an empty mask, so it is excluded explicitly
  assign match = x_valid && !load && (len != '0) && (fill_nxt == len) && (((hist_nxt ^ pat) & mask) == '0);
  assign cnt_sat = &match_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat <= DEF_PAT;
      len <= DEF_LEN;
      fill <= '0;
      hist <= '0;
      y <= 1'b0;
      match_count <= '0;
    end else begin
      match_count <= clr_cnt ? '0 : (match && !cnt_sat) ? match_count + CNT_W'(1) : match_count;
      if (load) begin
        pat <= pat_in;
        len <= len_clamp;
        fill <= '0;
        hist <= '0;
        y <= 1'b0;
      end else if (x_valid) begin
        hist <= hist_nxt;
        fill <= (match && !overlap) ? '0 : fill_nxt;
        y <= match;
      end else begin
        y <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset_n, x, x_valid, overlap, load, clr_cnt;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic y, cnt_sat, y2, sat2;
  logic [7:0] mc;
  logic [1:0] mc2;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .len_in(len_in), .clr_cnt(clr_cnt),
    .y(y), .match_count(mc), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .len_in(len_in), .clr_cnt(clr_cnt),
    .y(y2), .match_count(mc2), .cnt_sat(sat2)
  );

  task step(input logic b, input logic v);
    x = b;
    x_valid = v;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task do_load(input logic [7:0] p, input logic [3:0] l);
    load = 1'b1;
    pat_in = p;
    len_in = l;
    x = 1'b1;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    x_valid = 1'b0;
  endtask

  task do_reset;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task test_reset;
    reset_n = 1'b1;
    x = 1'b0; x_valid = 1'b0; overlap = 1'b1; load = 1'b0; clr_cnt = 1'b0;
    pat_in = '0; len_in = '0;
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({y, mc, cnt_sat, y2, mc2, sat2} !== 14'b0)
      $display("FAIL reset_outputs: got y=%b mc=%0d sat=%b y2=%b mc2=%0d sat2=%b, want all 0", y, mc, cnt_sat, y2, mc2, sat2);
    else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task test_overlap;
    logic [7:0] s, e;
    s = 8'b1011_0110;
    e = 8'b0000_1001;
    do_reset;
    overlap = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (y !== e[i]) $display("FAIL overlap_y bit%0d: got %b want %b", 8 - i, y, e[i]);
      else passed++;
    end
    total++;
    if (mc !== 8'd2) $display("FAIL overlap_count: got %0d want 2", mc);
    else passed++;
  endtask

  task test_non_overlap;
    logic [7:0] s, e;
    s = 8'b1011_0110;
    e = 8'b0000_1000;
    do_reset;
    overlap = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (y !== e[i]) $display("FAIL nonoverlap_y bit%0d: got %b want %b", 8 - i, y, e[i]);
      else passed++;
    end
    total++;
    if (mc !== 8'd1) $display("FAIL nonoverlap_count: got %0d want 1", mc);
    else passed++;
  endtask

  task test_valid_gating;
    logic [7:0] s;
    s = 8'hA5;
    do_reset;
    overlap = 1'b1;
    do_load(8'hA5, 4'd8);
    total++;
    if (y !== 1'b0) $display("FAIL load_y: got %b want 0", y);
    else passed++;
    for (int i = 7; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (y !== (i == 0)) $display("FAIL gated_valid_y bit%0d: got %b want %b", 8 - i, y, i == 0);
      else passed++;
      step(~s[i], 1'b0);
      total++;
      if (y !== 1'b0) $display("FAIL gated_invalid_y after bit%0d: got %b want 0", 8 - i, y);
      else passed++;
    end
    total++;
    if (mc !== 8'd1) $display("FAIL gated_count: got %0d want 1", mc);
    else passed++;
  endtask

  task test_len_zero_and_clamp;
    logic [9:0] d;
    logic [11:0] s, e;
    d = 10'b10110_10110;
    s = 12'b0100_1010_0101;
    e = 12'b0000_0000_0001;
    do_reset;
    overlap = 1'b1;
    do_load(8'h16, 4'd0);
    for (int i = 9; i >= 0; i--) begin
      step(d[i], 1'b1);
      total++;
      if (y !== 1'b0) $display("FAIL len0_y bit%0d: got %b want 0", 10 - i, y);
      else passed++;
    end
    total++;
    if (mc !== 8'd0) $display("FAIL len0_count: got %0d want 0", mc);
    else passed++;
    do_load(8'hA5, 4'd15);
    for (int i = 11; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (y !== e[i]) $display("FAIL clamp_y bit%0d: got %b want %b", 12 - i, y, e[i]);
      else passed++;
    end
    total++;
    if (mc !== 8'd1) $display("FAIL clamp_count: got %0d want 1", mc);
    else passed++;
  endtask

  task test_saturation;
    logic [1:0] want;
    do_reset;
    overlap = 1'b1;
    do_load(8'h01, 4'd1);
    for (int i = 0; i < 6; i++) begin
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      step(1'b1, 1'b1);
      total++;
      if (y2 !== 1'b1 || mc2 !== want || sat2 !== (i >= 2))
        $display("FAIL sat_step%0d: got y=%b cnt=%0d sat=%b want y=1 cnt=%0d sat=%b", i + 1, y2, mc2, sat2, want, i >= 2);
      else passed++;
    end
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    clr_cnt = 1'b0;
    total++;
    if (y2 !== 1'b1 || mc2 !== 2'd0 || sat2 !== 1'b0)
      $display("FAIL clr_with_match: got y=%b cnt=%0d sat=%b want y=1 cnt=0 sat=0", y2, mc2, sat2);
    else passed++;
    step(1'b0, 1'b1);
    total++;
    if (y2 !== 1'b0 || mc2 !== 2'd0)
      $display("FAIL after_clr: got y=%b cnt=%0d want y=0 cnt=0", y2, mc2);
    else passed++;
  endtask

  task test_async_reset;
    logic [7:0] s;
    logic [4:0] t, e;
    s = 8'b1011_0101;
    t = 5'b10110;
    e = 5'b00001;
    do_reset;
    overlap = 1'b1;
    for (int i = 7; i >= 0; i--) step(s[i], 1'b1);
    total++;
    if (mc !== 8'd1) $display("FAIL prereset_count: got %0d want 1", mc);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (y !== 1'b0 || mc !== 8'd0 || cnt_sat !== 1'b0)
      $display("FAIL async_reset: got y=%b cnt=%0d sat=%b want all 0", y, mc, cnt_sat);
    else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      step(t[i], 1'b1);
      total++;
      if (y !== e[i]) $display("FAIL postreset_y bit%0d: got %b want %b", 5 - i, y, e[i]);
      else passed++;
    end
    total++;
    if (mc !== 8'd1) $display("FAIL postreset_count: got %0d want 1", mc);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_overlap;
    test_non_overlap;
    test_valid_gating;
    test_len_zero_and_clamp;
    test_saturation;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
